multi_cycle_control: RTL and testbench
======================================

Name: multi_cycle_control

Overview:
- Moore-style control FSM that sequences the MIPS multi-cycle datapath.
- Each instruction takes 3-5 states: FETCH, DECODE, then an opcode-specific path. Memory states stall on a ready handshake.
- Supports the same instruction set and ALU-op encoding as the single-cycle controller. It replaces that controller in the multi-cycle processor top.

Parameters:
- STATE_W, 4, width of the state register and of the CurState debug port.

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- Reset_L  input  1  synchronous active-low reset, sampled on rising edge of CLK
- Opcode  input  6  instr[31:26] from the instruction register; sampled in DECODE only
- MemReady  input  1  memory completes the current access this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by ALU Zero (datapath ANDs it)
- IorD  output  1  0 = memory address from PC, 1 = from ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  load the instruction register
- MemToReg  output  1  write-back source: 1 = MDR, 0 = ALUOut
- RegDst  output  1  1 = rd, 0 = rt
- RegWrite  output  1  register-file write enable
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = ext(imm), 11 = ext(imm)<<2
- SignExtend  output  1  1 = sign-extend imm16, 0 = zero-extend
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUOp  output  4  ALU operation code (FUNC = 4'b1111 means decode from funct)
- IllegalOp  output  1  one-cycle pulse on an unsupported opcode
- CurState  output  STATE_W  current state, for debug and the bench

Behaviour:
- Reset:
  - While Reset_L=0 at a clock edge, the state goes to FETCH and the latched opcode goes to 0.
  - During any cycle with Reset_L=0, all outputs are forced to 0.
  - A reset mid-access (a stalled memory state) abandons the access; no write-back occurs.
- Opcode latching: Opcode is latched into an internal register on exit from DECODE. All later states use the latched copy.
- Output rule: outputs are decoded from the state and the latched opcode. The only exception is MemReady gating, listed per state. Unlisted outputs are 0.
- States and transitions:
  - FETCH(0):
    - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD(0010), PCSource=00.
    - IRWrite = PCWrite = MemReady.
    - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE(1):
    - Outputs: ALUSrcA=0, ALUSrcB=11, SignExtend=1, ALUOp=ADD.
    - Next state by opcode:
      - LW 100011 or SW 101011 -> MEMADR.
      - R-type 000000 -> EXECUTE.
      - BEQ 000100 -> BRANCH.
      - J 000010 -> JUMP.
      - ORI, ADDI, ADDIU, ANDI, LUI, SLTI, SLTIU, XORI (001101, 001000, 001001, 001100, 001111, 001010, 001011, 001110) -> IEXEC.
      - Any other opcode -> ILLEGAL.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, SignExtend=1, ALUOp=ADD. Goes to MEMREAD for LW, MEMWRITE for SW.
  - MEMREAD(3): MemRead=1, IorD=1. Holds while MemReady=0, then goes to MEMWB.
  - MEMWB(4): RegWrite=1, MemToReg=1, RegDst=0. Goes to FETCH.
  - MEMWRITE(5): MemWrite=1, IorD=1. Holds while MemReady=0, then goes to FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=FUNC. Goes to RWB.
  - RWB(7): RegWrite=1, RegDst=1, MemToReg=0. Goes to FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=SUB(0110), PCWriteCond=1, PCSource=01. Goes to FETCH.
  - JUMP(9): PCWrite=1, PCSource=10. Goes to FETCH.
  - IEXEC(10):
    - Outputs: ALUSrcA=1, ALUSrcB=10. Goes to IWB.
    - ALUOp by latched opcode: ORI=OR 0001, ADDI=ADD 0010, ADDIU=ADDU 1000, ANDI=AND 0000, LUI=LUI 1110, SLTI=SLT 0111, SLTIU=SLTU 1011, XORI=XOR 1010.
    - SignExtend=1 for ADDI, SLTI, SLTIU; 0 for the others.
  - IWB(11): RegWrite=1, RegDst=0, MemToReg=0. ALUOp and SignExtend are held as in IEXEC. Goes to FETCH.
  - ILLEGAL(12): IllegalOp=1 for exactly one cycle, no writes. Goes to FETCH.
  - Codes 13-15: unreachable; if entered, go to FETCH with all outputs 0.
- Latency with MemReady tied high:
  - 3 cycles: BEQ, J, ILLEGAL.
  - 4 cycles: R-type, I-type ALU, SW.
  - 5 cycles: LW.
- Each stall cycle adds 1 cycle to that count.
- MemRead and MemWrite are never asserted together. At most one of PCWrite and PCWriteCond is 1 in any cycle.

Decomposition:
- Shared package mips_defs holds:
  - the opcode constants;
  - the 4-bit ALU-op constants (AND..FUNC);
  - the state encodings;
  - the ALUSrcB and PCSource select encodings.
- The single-cycle controller also moves to this package.
- Natural sub-module: imm_alu_decode. It is combinational: latched opcode -> {ALUOp, SignExtend} for the I-type ALU group.

Test Plan:
- Reset_L=0 for 2 cycles, then release with MemReady=1 -> CurState=0 and all outputs 0 during reset. First post-reset cycle: MemRead=1, IRWrite=1, PCWrite=1.
- R-type (Opcode=000000), MemReady=1 -> states 0,1,6,7,0. ALUOp=1111 in EXECUTE; RegWrite=1 and RegDst=1 only in RWB.
- LW with MemReady low for 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4,0. IorD=1 throughout MEMREAD; RegWrite=1 and MemToReg=1 once.
- Sweep all 8 I-type opcodes -> ALUOp and SignExtend match the IEXEC list (e.g. SLTIU: 1011 and 1). Each takes 4 cycles.
- BEQ and J -> BRANCH: PCWriteCond=1, PCSource=01, ALUOp=0110. JUMP: PCWrite=1, PCSource=10. Each takes 3 cycles.
- Opcode=111111 -> IllegalOp high exactly 1 cycle, then FETCH. Also: assert Reset_L=0 while stalled in MEMWRITE -> MemWrite drops that cycle and the next state is FETCH.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS control definitions: opcodes, ALU-op codes, mux selects,
// multi-cycle state encodings and the single-cycle main decoder.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ADDU = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_LUI  = 4'b1110;
    localparam logic [3:0] ALU_FUNC = 4'b1111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IEXEC    = 4'd10,
        S_IWB      = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    function automatic logic is_imm_alu(input logic [5:0] op);
        return (op == OP_ORI)  || (op == OP_ADDI)  || (op == OP_ADDIU) || (op == OP_ANDI) ||
               (op == OP_LUI)  || (op == OP_SLTI)  || (op == OP_SLTIU) || (op == OP_XORI);
    endfunction

    // {alu_op, sign_ext} for the immediate ALU group; ADD/zero-ext otherwise.
    function automatic logic [4:0] imm_decode(input logic [5:0] op);
        case (op)
            OP_ORI:   return {ALU_OR,   1'b0};
            OP_ADDI:  return {ALU_ADD,  1'b1};
            OP_ADDIU: return {ALU_ADDU, 1'b0};
            OP_ANDI:  return {ALU_AND,  1'b0};
            OP_LUI:   return {ALU_LUI,  1'b0};
            OP_SLTI:  return {ALU_SLT,  1'b1};
            OP_SLTIU: return {ALU_SLTU, 1'b1};
            OP_XORI:  return {ALU_XOR,  1'b0};
            default:  return {ALU_ADD,  1'b0};
        endcase
    endfunction

    function automatic state_t decode_next(input logic [5:0] op);
        if (op == OP_LW || op == OP_SW) return S_MEMADR;
        if (op == OP_RTYPE)             return S_EXECUTE;
        if (op == OP_BEQ)               return S_BRANCH;
        if (op == OP_J)                 return S_JUMP;
        if (is_imm_alu(op))             return S_IEXEC;
        return S_ILLEGAL;
    endfunction

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       sign_ext;
        logic [3:0] alu_op;
        logic       illegal;
    } sc_ctrl_t;

    // Single-cycle main decoder, kept here so both controllers share one ISA view.
    function automatic sc_ctrl_t sc_decode(input logic [5:0] op);
        sc_ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_FUNC; end
            OP_LW: begin
                c.alu_src = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
                c.mem_read = 1'b1; c.sign_ext = 1'b1; c.alu_op = ALU_ADD;
            end
            OP_SW: begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.sign_ext = 1'b1; c.alu_op = ALU_ADD; end
            OP_BEQ: begin c.branch = 1'b1; c.sign_ext = 1'b1; c.alu_op = ALU_SUB; end
            OP_J:   c.jump = 1'b1;
            default: begin
                if (is_imm_alu(op)) begin
                    c.alu_src   = 1'b1;
                    c.reg_write = 1'b1;
                    {c.alu_op, c.sign_ext} = imm_decode(op);
                end else begin
                    c.illegal = 1'b1;
                end
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_cycle_control_imm_alu_decode.sv
// Latched opcode -> ALU operation and immediate extension for I-type ALU ops.
module imm_alu_decode
    import mips_defs::*;
(
    input  logic [5:0] opcode,
    output logic [3:0] alu_op,
    output logic       sign_ext
);

    always_comb begin
        {alu_op, sign_ext} = imm_decode(opcode);
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore control FSM sequencing the MIPS multi-cycle datapath.
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 when memory is ready
// DECODE   | register read, branch target into ALUOut, latch opcode
// MEMADR   | compute load/store address
// MEMREAD  | load access, waits on MemReady
// MEMWB    | load data to rt
// MEMWRITE | store access, waits on MemReady
// EXECUTE  | R-type ALU operation
// RWB      | ALU result to rd
// BRANCH   | BEQ compare, conditional PC load
// JUMP     | PC <= jump target
// IEXEC    | immediate ALU operation
// IWB      | immediate result to rt
// ILLEGAL  | one-cycle IllegalOp pulse
module multi_cycle_control
    import mips_defs::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [5:0]         Opcode,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               SignExtend,
    output logic [1:0]         PCSource,
    output logic [3:0]         ALUOp,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] CurState
);

    state_t     state;
    logic [5:0] op_q;
    logic [3:0] imm_alu_op;
    logic       imm_sext;

    imm_alu_decode u_imm_dec (
        .opcode   (op_q),
        .alu_op   (imm_alu_op),
        .sign_ext (imm_sext)
    );

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            case (state)
                S_FETCH:    if (MemReady) state <= S_DECODE;
                S_DECODE: begin
                    op_q  <= Opcode;
                    state <= decode_next(Opcode);
                end
                S_MEMADR:   state <= (op_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (MemReady) state <= S_MEMWB;
                S_MEMWRITE: if (MemReady) state <= S_FETCH;
                S_EXECUTE:  state <= S_RWB;
                S_IEXEC:    state <= S_IWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Reset must blank the outputs in the same cycle, so decode is combinational off the state.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        SignExtend  = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALU_AND;
        IllegalOp   = 1'b0;
        if (Reset_L) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    ALUOp   = ALU_ADD;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE: begin
                    ALUSrcB    = SRCB_IMM_SH;
                    SignExtend = 1'b1;
                    ALUOp      = ALU_ADD;
                end
                S_MEMADR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_IMM;
                    SignExtend = 1'b1;
                    ALUOp      = ALU_ADD;
                end
                S_MEMREAD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                S_MEMWRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_FUNC;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                S_IEXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_IMM;
                    ALUOp      = imm_alu_op;
                    SignExtend = imm_sext;
                end
                S_IWB: begin
                    RegWrite   = 1'b1;
                    ALUOp      = imm_alu_op;
                    SignExtend = imm_sext;
                end
                S_ILLEGAL: IllegalOp = 1'b1;
                default: ;
            endcase
        end
    end

    assign CurState = STATE_W'(state);

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: a per-cycle script of expected states
// built from instruction class and stall counts, checked against a table model.
module tb_multi_cycle_control;

    logic       CLK = 1'b0;
    logic       Reset_L;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemToReg, RegDst, RegWrite, ALUSrcA, SignExtend, IllegalOp;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOp;
    logic [3:0] CurState;

    multi_cycle_control #(.STATE_W(4)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .SignExtend(SignExtend),
        .PCSource(PCSource), .ALUOp(ALUOp), .IllegalOp(IllegalOp),
        .CurState(CurState)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         st;
        bit         chk_st;
        bit         rdy;
        bit         rst_b;
        logic [5:0] op;
        int         tag;
    } ent_t;

    ent_t script[$];

    logic [5:0] imm_ops [8] = '{6'b001101, 6'b001000, 6'b001001, 6'b001100,
                               6'b001111, 6'b001010, 6'b001011, 6'b001110};
    logic [3:0] imm_alu [8] = '{4'b0001, 4'b0010, 4'b1000, 4'b0000,
                               4'b1110, 4'b0111, 4'b1011, 4'b1010};
    bit         imm_sx  [8] = '{0, 1, 0, 0, 0, 1, 1, 0};

    logic [19:0] dut_vec;
    assign dut_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                      RegDst, RegWrite, ALUSrcA, ALUSrcB, SignExtend, PCSource, ALUOp, IllegalOp};

    function automatic int imm_idx(input logic [5:0] op);
        for (int i = 0; i < 8; i++) if (imm_ops[i] == op) return i;
        return -1;
    endfunction

    // Expected outputs straight from the per-state output listing.
    function automatic logic [19:0] exp_out(input int st, input logic [5:0] lop,
                                            input bit rdy, input bit rst_b);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0;
        logic rdst = 0, rw = 0, srca = 0, sx = 0, ill = 0;
        logic [1:0] srcb = 0, pcs = 0;
        logic [3:0] aop = 0;
        int k = imm_idx(lop);
        if (!rst_b) return 20'h0;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; aop = 4'b0010; irw = rdy; pcw = rdy; end
            1:  begin srcb = 2'b11; sx = 1; aop = 4'b0010; end
            2:  begin srca = 1; srcb = 2'b10; sx = 1; aop = 4'b0010; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 4'b1111; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin srca = 1; aop = 4'b0110; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin srca = 1; srcb = 2'b10;
                      if (k >= 0) begin aop = imm_alu[k]; sx = imm_sx[k]; end end
            11: begin rw = 1;
                      if (k >= 0) begin aop = imm_alu[k]; sx = imm_sx[k]; end end
            12: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, sx, pcs, aop, ill};
    endfunction

    function automatic void add(input int st, input bit rdy, input bit rst_b,
                                input logic [5:0] op, input bit chk_st = 1);
        ent_t e;
        e.st = st; e.chk_st = chk_st; e.rdy = rdy; e.rst_b = rst_b; e.op = op; e.tag = 0;
        script.push_back(e);
    endfunction

    function automatic void tag_last(input int t);
        script[script.size()-1].tag = t;
    endfunction

    // Builds the state sequence of one instruction; the opcode bus carries junk after DECODE.
    task automatic add_instr(input logic [5:0] op, input int fstall, input int mstall,
                             input bit idle, input int exp_len, input string name);
        int n0 = script.size();
        int k = imm_idx(op);
        logic [5:0] junk = 6'b111111;
        repeat (fstall) add(0, 0, 1, op);
        add(0, 1, 1, op);
        add(1, idle, 1, op);
        if (op == 6'b100011) begin
            add(2, idle, 1, junk);
            repeat (mstall) add(3, 0, 1, junk);
            add(3, 1, 1, junk);
            add(4, idle, 1, junk);
        end else if (op == 6'b101011) begin
            add(2, idle, 1, junk);
            repeat (mstall) add(5, 0, 1, junk);
            add(5, 1, 1, junk);
        end else if (op == 6'b000000) begin
            add(6, idle, 1, junk); add(7, idle, 1, junk);
        end else if (op == 6'b000100) begin
            add(8, idle, 1, junk);
        end else if (op == 6'b000010) begin
            add(9, idle, 1, junk);
        end else if (k >= 0) begin
            add(10, idle, 1, junk);
            if (op == 6'b001011) tag_last(2);
            add(11, idle, 1, junk);
        end else begin
            add(12, idle, 1, junk);
            tag_last(3);
        end
        checks++;
        if (script.size() - n0 != exp_len) begin
            errors++;
            $display("FAIL latency_%s: model=%0d cycles required=%0d", name,
                     script.size() - n0, exp_len);
        end
    endtask

    task automatic pin(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        logic [5:0] lop = 6'b0;
        logic [19:0] ev;
        Reset_L = 1'b0; MemReady = 1'b1; Opcode = 6'b0;

        add(0, 1, 0, 6'b0, 0);
        add(0, 1, 0, 6'b0, 1);
        add_instr(6'b000000, 0, 0, 1, 4, "rtype");
        tag_last(0);
        script[2].tag = 1;
        add_instr(6'b100011, 0, 3, 1, 8, "lw_stall3");
        add_instr(6'b101011, 0, 1, 1, 5, "sw_stall1");
        for (int i = 0; i < 8; i++) add_instr(imm_ops[i], 0, 0, i[0], 4, "imm");
        add_instr(6'b000100, 0, 0, 1, 3, "beq");
        add_instr(6'b000010, 0, 0, 0, 3, "j");
        add_instr(6'b111111, 0, 0, 1, 3, "illegal");
        add_instr(6'b000000, 2, 0, 0, 6, "rtype_fstall2");
        add_instr(6'b100011, 0, 0, 1, 5, "lw");
        add_instr(6'b010001, 1, 0, 1, 4, "illegal_cop1");
        add(0, 1, 1, 6'b101011);
        add(1, 1, 1, 6'b101011);
        add(2, 1, 1, 6'b111111);
        add(5, 0, 1, 6'b111111);
        add(5, 0, 0, 6'b111111);
        tag_last(4);
        add_instr(6'b001011, 0, 0, 1, 4, "sltiu_after_reset");

        #1;
        foreach (script[i]) begin
            Reset_L  = script[i].rst_b;
            MemReady = script[i].rdy;
            Opcode   = script[i].op;
            #1;
            if (script[i].chk_st) begin
                checks++;
                if (CurState !== script[i].st[3:0]) begin
                    errors++;
                    $display("FAIL state[%0d]: actual=%0d required=%0d", i, CurState, script[i].st);
                end
            end
            ev = exp_out(script[i].st, lop, script[i].rdy, script[i].rst_b);
            checks++;
            if (dut_vec !== ev) begin
                errors++;
                $display("FAIL outputs[%0d] st=%0d: actual=%h required=%h", i, script[i].st, dut_vec, ev);
            end
            checks++;
            if ((MemRead && MemWrite) || (PCWrite && PCWriteCond)) begin
                errors++;
                $display("FAIL exclusive[%0d]: actual rd/wr/pcw/pcwc=%b%b%b%b required no overlap",
                         i, MemRead, MemWrite, PCWrite, PCWriteCond);
            end
            case (script[i].tag)
                1: pin("first_fetch", {5'b0, MemRead, IRWrite, PCWrite}, 8'h07);
                2: pin("sltiu_iexec", {3'b0, ALUOp, SignExtend}, 8'h17);
                3: pin("illegal_pulse", {7'b0, IllegalOp}, 8'h01);
                4: pin("memwrite_reset", {7'b0, MemWrite}, 8'h00);
                default: ;
            endcase
            if (!script[i].rst_b) lop = 6'b0;
            else if (script[i].st == 1) lop = script[i].op;
            @(posedge CLK);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
